program_loader: RTL and testbench

//  Serial boot loader sitting upstream of the CPU core. Consumes a byte stream from the

---
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: serial boot loader framing UART bytes into 16-bit program memory writes
// and holding the CPU in reset until a checksummed image has been loaded.
module program_loader #(
    parameter int         ROM_ADDR_WIDTH = 8,
    parameter int         ROM_WIDTH      = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      rom_we,
    output logic [ROM_ADDR_WIDTH-1:0] rom_waddr,
    output logic [ROM_WIDTH-1:0]      rom_wdata,
    output logic                      cpu_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT_HDR, GET_LEN, GET_HI, GET_LO, GET_CSUM, DONE, ERROR} state_t;

    state_t                    state;
    logic [ROM_ADDR_WIDTH-1:0] idx, last;
    logic [7:0]                hi, csum;
    logic [TW-1:0]             timer;
    logic                      acc;

    assign acc = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            rx_ready  <= 1'b0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
            last      <= '0;
            hi        <= '0;
            csum      <= '0;
            timer     <= '0;
        end else begin
            rom_we <= 1'b0;
            if (state inside {IDLE, DONE, ERROR}) begin
                if (start) begin
                    state    <= WAIT_HDR;
                    rx_ready <= 1'b1;
                    cpu_rst  <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    error    <= 1'b0;
                    idx      <= '0;
                    csum     <= '0;
                    timer    <= '0;
                end
            end else if (acc) begin
                timer <= '0;
                case (state)
                    WAIT_HDR: if (rx_data == SYNC_BYTE) state <= GET_LEN;
                    GET_LEN: begin
                        // LEN of zero selects a full memory image
                        last  <= rx_data == 8'd0 ? '1 : ROM_ADDR_WIDTH'(rx_data - 8'd1);
                        state <= GET_HI;
                    end
                    GET_HI: begin
                        hi    <= rx_data;
                        csum  <= csum + rx_data;
                        state <= GET_LO;
                    end
                    GET_LO: begin
                        csum      <= csum + rx_data;
                        rom_we    <= 1'b1;
                        rom_waddr <= idx;
                        rom_wdata <= ROM_WIDTH'({hi, rx_data});
                        idx       <= idx + 1'b1;
                        state     <= idx == last ? GET_CSUM : GET_HI;
                    end
                    GET_CSUM: begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= csum == rx_data;
                        error    <= csum != rx_data;
                        cpu_rst  <= csum != rx_data;
                        state    <= csum == rx_data ? DONE : ERROR;
                    end
                    default: ;
                endcase
            end else if (state != WAIT_HDR && TIMEOUT_CYCLES != 0) begin
                if (timer == TLAST) begin
                    state    <= ERROR;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                    error    <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frames against a queue-based reference model; writes and
// load outcomes are checked by an independent monitor.
module tb_program_loader;
    logic        clk = 0, rst = 0, start = 0, rx_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready, rom_we, cpu_rst, busy, done, error;
    logic [7:0]  rom_waddr;
    logic [15:0] rom_wdata;

    int n_cmp = 0, n_err = 0;
    logic [23:0] wq[$];
    logic [4:0]  oq[$];
    logic [15:0] img[256];

    program_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every write and every load completion is matched against the scoreboard
    initial begin
        logic prev_fin = 0;
        forever begin
            @(negedge clk);
            if (rom_we) begin
                if (wq.size() == 0) check("unexpected_write", {8'h0, rom_waddr, rom_wdata}, 32'hFFFFFFFF);
                else check("write", {8'h0, rom_waddr, rom_wdata}, {8'h0, wq.pop_front()});
            end
            if ((done || error) && !prev_fin) begin
                if (oq.size() == 0) check("unexpected_outcome", {done, error}, 0);
                else check("outcome", {done, error, cpu_rst, busy, rx_ready}, oq.pop_front());
            end
            prev_fin = done || error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int gap();
        return $urandom_range(0, 3);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int g);
        int k;
        repeat (g) @(negedge clk);
        rx_valid = 1;
        rx_data  = b;
        for (k = 0; k < 50 && !rx_ready; k++) @(negedge clk);
        if (!rx_ready) check("rx_ready_wait", 0, 1);
        else @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_state", {busy, cpu_rst, done, error, rx_ready}, 5'b11001);
    endtask

    // reference model: expected writes are simply the image words in order, outcome from the byte sum
    task automatic run_frame(input int n, input bit bad, input int junk, input bit mid_start);
        logic [7:0] csum = 0, b;
        for (int i = 0; i < n; i++) begin
            wq.push_back({i[7:0], img[i]});
            csum = csum + img[i][15:8] + img[i][7:0];
        end
        if (bad) csum = csum + 8'd1;
        oq.push_back(bad ? 5'b01100 : 5'b10000);
        do_start();
        for (int j = 0; j < junk; j++) begin
            b = j == 0 ? 8'h00 : j == 1 ? 8'hFF : j == 2 ? 8'h5A : 8'($urandom);
            send_byte(b == 8'hA5 ? 8'h3C : b, gap());
        end
        send_byte(8'hA5, gap());
        send_byte(8'(n), gap());
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == n / 2) begin
                start = 1;
                @(negedge clk);
                start = 0;
            end
            send_byte(img[i][15:8], gap());
            send_byte(img[i][7:0], gap());
        end
        send_byte(csum, gap());
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1;
        #1;
        check("reset_outputs", {rom_we, rom_waddr, rom_wdata, rx_ready, cpu_rst, busy, done, error}, 30'h00000008);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        run_frame(2, 0, 0, 0);
        run_frame(2, 1, 0, 0);
        run_frame(2, 0, 3, 0);
        for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
        run_frame(256, 0, 0, 0);
        // timeout: silence after the first data byte
        oq.push_back(5'b01100);
        do_start();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        for (k = 1; k <= 40 && !error; k++) @(negedge clk);
        check("timeout_cycles", k - 1, 16);
        repeat (2) @(negedge clk);
        // reset in the middle of a word
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        wq.push_back({8'h00, 16'h1234});
        do_start();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        #1 rst = 1;
        #1;
        check("midload_reset", {rom_we, rom_waddr, rom_wdata, rx_ready, cpu_rst, busy, done, error}, 30'h00000008);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_frame(2, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) img[i] = 16'($urandom);
            run_frame(n, bit'($urandom_range(0, 1)), $urandom_range(0, 5), bit'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        check("writes_drained", wq.size(), 0);
        check("outcomes_drained", oq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
